// File: rtl/ysyx_23060240_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060240_ifu
//
// Instruction-fetch responder for the core's pc/inst interface. It accepts a
// fetch request carrying a byte pc. After LATENCY cycles it returns the 32-bit
// word held in a local instruction memory. Out-of-range fetches come back as
// a faulting zero word. A loader port fills the memory at any time, including
// while rst is high.
//
// Optional feature (compile-time macro):
//   IFU_MISALIGN_CHECK_EN - an in-range fetch with pc[1:0] != 0 returns
//                           ebreak (32'h0010_0073) with fault set. When the
//                           macro is undefined, pc[1:0] is ignored.
//
// Parameters:
//   DEPTH    memory size in 32-bit words (power of two)
//   LATENCY  cycles from accept to resp_valid (1..15)
//   BASE     byte address of memory word 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      fetch request handshake, req_pc = byte address
//   resp_valid/resp_ready    response handshake
//   resp_inst/resp_fault     returned word and its fault flag
//   ld_en/ld_addr/ld_data    loader write port (word index)
// ----------------------------------------------------------------------------
module ysyx_23060240_ifu #(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    localparam int         AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_pc,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_inst,
    output logic          resp_fault,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_pc_q;
    logic [31:0] r_resp_inst;
    logic        r_resp_fault;
    logic [31:0] r_mem [DEPTH];

    logic        w_req_ready;
    logic        w_accept;
    logic        w_load_resp;
    logic [31:0] w_pc;
    logic [29:0] w_off_w;
    logic [AW-1:0] w_idx;
    logic        w_range_err;
    logic        w_misalign;

    // ------------------------------------------------------------------------
    // Address decode. With LATENCY==1 the response is built on the accept edge
    // straight from req_pc. Otherwise it is built from the latched pc at the
    // end of WAIT. This way one decoder serves both paths.
    // ------------------------------------------------------------------------
    assign w_pc        = (r_state == S_WAIT) ? r_pc_q : req_pc;
    assign w_off_w     = 30'((w_pc - BASE) >> 2);
    assign w_idx       = w_off_w[AW-1:0];
    // An offset past the end also covers pcs that wrap around below BASE.
    // The explicit compare keeps that case obvious.
    assign w_range_err = (w_pc < BASE) || (w_off_w >= DEPTH_W);

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_misalign  = (w_pc[1:0] != 2'b00);
`else
    assign w_misalign  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic.
    // RESP keeps ready high while the consumer takes the response. This lets
    // a new request overlap the handshake, so back-to-back fetches need no
    // idle bubble.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        w_req_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready);
        w_accept    = req_valid && w_req_ready;
        w_load_resp = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                    w_load_resp = (LATENCY == 1);
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_load_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    if (w_accept) begin
                        w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                        w_load_resp = (LATENCY == 1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, countdown and response registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            // Every register then samples pre-edge values, whatever the
            // order of the statements.
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_pc_q       <= 32'h0;
            r_resp_inst  <= 32'h0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_pc_q <= req_pc;
            end

            if (w_accept && (LATENCY > 1)) begin
                r_cnt <= 4'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // The memory read sees the pre-edge contents. A loader write on
            // this same edge is therefore not part of this response.
            if (w_load_resp) begin
                if (w_range_err) begin
                    r_resp_inst  <= 32'h0;
                    r_resp_fault <= 1'b1;
                end else if (w_misalign) begin
                    r_resp_inst  <= EBREAK;
                    r_resp_fault <= 1'b1;
                end else begin
                    r_resp_inst  <= r_mem[w_idx];
                    r_resp_fault <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Instruction memory. The loader writes it in every state, and also while
    // rst is high.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset. Contents come only from the loader,
        // and a reset branch here would stop it mapping onto a RAM.
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_inst  = r_resp_inst;
    assign resp_fault = r_resp_fault;

endmodule

// File: doc/ysyx_23060240_ifu.md
# ysyx_23060240_ifu

Instruction-fetch responder that sits on the opposite side of the core's pc/inst interface. It accepts a fetch request carrying a pc and returns the 32-bit instruction word from an internal instruction memory after a configurable latency. It flags out-of-range fetches, and optionally misaligned fetches. A loader write port lets the simulation environment fill the memory before and during execution.

## Interface
Parameters:
- DEPTH, 1024: instruction memory size in 32-bit words; power of two; AW = $clog2(DEPTH).
- LATENCY, 1: cycles from request acceptance to resp_valid assertion; legal range 1..15.
- BASE, 32'h8000_0000: byte address of memory word 0; equals the core reset pc.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block can accept a request this cycle.
- req_pc  in  32  fetch byte address.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_inst  out  32  fetched instruction word.
- resp_fault  out  1  fetch failed; resp_inst holds the substitute word.
- ld_en  in  1  loader write enable.
- ld_addr  in  AW  loader word index.
- ld_data  in  32  loader write data.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready).
- Accept occurs when req_valid && req_ready. On accept:
  - latch pc_q = req_pc;
  - compute off = req_pc - BASE (32-bit wrap) and idx = off[AW+1:2];
  - range_err = (req_pc < BASE) || (off[31:2] >= DEPTH).
- Accept transitions:
  - LATENCY==1: next state RESP, response registered on the accept edge.
  - LATENCY>1: cnt loads LATENCY-1 and the next state is WAIT.
- In WAIT, cnt decrements each cycle. When cnt==1 on an edge, the block registers the response and the next state is RESP.
- Response registration:
  - range_err: resp_inst=32'h0000_0000 and resp_fault=1.
  - Otherwise: resp_inst=mem[idx] and resp_fault=0.
- In RESP, resp_valid=1 and resp_inst/resp_fault are held stable until resp_ready. On handshake:
  - next state IDLE, or
  - if a new request is accepted the same cycle, it is processed per the accept rules.
- The loader writes mem[ld_addr]=ld_data on any edge with ld_en, in any state, including during reset.
- Read/write collision: the read is read-before-write. A write on the same edge the response is registered is not visible in that response. A write on an earlier edge is visible.
- Memory contents are not reset.

## Timing
- Reset values: state=IDLE, cnt=0, resp_valid=0, resp_inst=32'h0, resp_fault=0. req_ready=1 from the first cycle after reset.
- Reset mid-operation discards any pending WAIT/RESP transaction. No response is produced for it.
- Latency: request accepted at edge T gives resp_valid=1 in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles later.
- Throughput:
  - with resp_ready held high, one response every LATENCY cycles when LATENCY==1;
  - otherwise one response every LATENCY cycles, because RESP overlaps the next accept.
- resp_valid is never withdrawn before the handshake, and the payload does not change while resp_valid && !resp_ready.
- req_pc is sampled only at accept; it may change afterwards.

## Configuration
- IFU_MISALIGN_CHECK_EN:
  - Defined: an accepted request with req_pc[1:0]!=0 and no range_err returns resp_inst=32'h0010_0073 (ebreak) with resp_fault=1, so the core halts via its ebreak path. range_err takes precedence (inst 0, fault 1).
  - Undefined: req_pc[1:0] is ignored, the word at idx is returned and resp_fault=0.

## Test plan
- Reset: hold rst 2 cycles with req_valid=1 -> resp_valid=0, resp_inst=0, resp_fault=0 during reset; req_ready=1 in the first cycle after reset.
- Basic fetch, LATENCY=1: load mem[0]=32'h0000_0413 and mem[1]=32'h0010_0073; request pc 32'h8000_0000 then 32'h8000_0004 back-to-back with resp_ready=1 -> responses 32'h0000_0413 then 32'h0010_0073, one per cycle, fault 0.
- Backpressure, LATENCY=3: request 32'h8000_0008 (mem[2]=32'hDEAD_BEEF) with resp_ready=0 for 5 cycles -> resp_valid rises 3 cycles after accept, stays high with a stable payload, req_ready=0 until resp_ready=1.
- Range fault: request 32'h7FFF_FFFC and BASE+4*DEPTH -> resp_inst=0, resp_fault=1 for each.
- Misaligned: request 32'h8000_0002 -> with IFU_MISALIGN_CHECK_EN, 32'h0010_0073 and fault 1; without it, mem[0] and fault 0.
- Collision/reset: with LATENCY=2, ld_en writes mem[3] on the edge the response is registered -> old word returned. Asserting rst while in WAIT -> no response emitted and state IDLE.
